// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM for the RMON counter store. Port A is the
// statistics read-modify-write path and port B is the CPU path. After each reset
// a sweep clears every word to zero.
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter     BLK_TYPE   = "M4K"
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  (* ramstyle = BLK_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clr_addr;

  // The sweep writes address clr_addr on each edge. init_done rises on the
  // edge that clears the last word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples its pre-edge value regardless of statement order.
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1)
        init_done <= 1'b1;
    end
  end

  // NOTE: the array is not reset, so it can still map onto a block RAM. The
  // clear sweep zeroes it instead.
  always_ff @(posedge Clk) begin
    if (!init_done) begin
      mem[clr_addr] <= '0;
    end else begin
      // Port A is written last, so it wins when both ports write the same address.
      if (wren_b)
        mem[address_b] <= data_b;
      if (wren_a)
        mem[address_a] <= data_a;
    end
  end

  // Each port reads its own write data. For the other port's write, the read
  // returns the pre-edge array contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_a <= '0;
      q_b <= '0;
    end else if (!init_done) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= wren_a ? data_a : mem[address_a];
      q_b <= wren_b ? data_b : mem[address_b];
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram. The driver queues the expected q and
// init_done values for each cycle. A monitor compares them just after each edge.
module tb_dual_port_ram;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] data_a, data_b;
  logic        wren_a, wren_b;
  logic [5:0]  address_a, address_b;
  logic [31:0] q_a, q_b;
  logic        init_done;

  int tests = 0;
  int fails = 0;
  int cyc_id = 0;

  typedef struct {
    int          id;
    bit          ca;
    logic [31:0] ea;
    bit          cb;
    logic [31:0] eb;
    logic        ed;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dual_port_ram dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .address_a (address_a),
    .q_a       (q_a),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .address_b (address_b),
    .q_b       (q_b),
    .init_done (init_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.ca) check($sformatf("q_a cyc%0d", mon_e.id), q_a, mon_e.ea);
      if (mon_e.cb) check($sformatf("q_b cyc%0d", mon_e.id), q_b, mon_e.eb);
      check($sformatf("init_done cyc%0d", mon_e.id), {31'd0, init_done}, {31'd0, mon_e.ed});
    end
  end

  // Drives one cycle of inputs at the falling edge and queues the expected
  // values that follow the next rising edge.
  task automatic cyc(input bit wa, input logic [5:0] aa, input logic [31:0] da,
                     input bit wb, input logic [5:0] ab, input logic [31:0] db,
                     input bit ca, input logic [31:0] ea,
                     input bit cb, input logic [31:0] eb, input logic ed);
    exp_t e;
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    e.id = cyc_id; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb; e.ed = ed;
    sb.push_back(e);
    cyc_id++;
    @(negedge Clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    #1;
    check("reset q_a", q_a, 32'h0);
    check("reset q_b", q_b, 32'h0);
    check("reset init_done", {31'd0, init_done}, 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Runs the full sweep from the negedge of reset release. A write to
  // address 40 is attempted on cycle 10 and must be ignored.
  task automatic full_sweep();
    for (int k = 1; k <= 64; k++)
      cyc(k == 10, 6'd40, 32'hFFFF_FFFF, 1'b0, 6'd0, 32'h0,
          1'b1, 32'h0, 1'b1, 32'h0, k == 64);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 64; i++)
      cyc(1'b0, 6'(63 - i), 32'h0, 1'b0, 6'(i), 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    {wren_a, wren_b} = '0;
    {address_a, address_b} = '0;
    {data_a, data_b} = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    full_sweep();
    read_all_zero();

    // Port A write, then port B reads the same address.
    cyc(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 6'd0, 32'h0, 1'b0, 6'd5, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    // Cross-port read-during-write returns the old word.
    cyc(1'b1, 6'd9, 32'h1234_5678, 1'b0, 6'd9, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 6'd0, 32'h0, 1'b0, 6'd9, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    // Both ports write address 63. Port A data is stored.
    cyc(1'b1, 6'd63, 32'hAAAA_0000, 1'b1, 6'd63, 32'h0000_BBBB,
        1'b1, 32'hAAAA_0000, 1'b1, 32'h0000_BBBB, 1'b1);
    cyc(1'b0, 6'd63, 32'h0, 1'b0, 6'd63, 32'h0, 1'b1, 32'hAAAA_0000, 1'b1, 32'hAAAA_0000, 1'b1);
    // Both ports write different addresses, then read them crossed.
    cyc(1'b1, 6'd1, 32'h1111_1111, 1'b1, 6'd2, 32'h2222_2222,
        1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1);
    cyc(1'b0, 6'd2, 32'h0, 1'b0, 6'd1, 32'h0, 1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111, 1'b1);
    // Port B writes while port A reads the same address: A sees the old word.
    cyc(1'b0, 6'd5, 32'h0, 1'b1, 6'd5, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0BAD_F00D, 1'b1);
    cyc(1'b0, 6'd5, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1);
    // Address 40 was written during the sweep and must still read zero.
    cyc(1'b0, 6'd40, 32'h0, 1'b0, 6'd40, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
    // Leave non-zero data on both q outputs before the next reset.
    cyc(1'b0, 6'd9, 32'h0, 1'b0, 6'd63, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 32'hAAAA_0000, 1'b1);
    drain();

    reset_pulse();
    // Abort the sweep at cycle 30, then run a full sweep after the second release.
    for (int k = 1; k <= 30; k++)
      cyc(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    drain();
    reset_pulse();
    full_sweep();
    read_all_zero();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
